// File: rtl/game_flow_ctrl.sv
// Game sequencer: debounces start/pause buttons and runs the idle/countdown/run/
// pause/crash/over play-state machine, producing scoreboard and renderer enables.
module game_flow_ctrl #(
    parameter int COUNTDOWN_FRAMES = 60,
    parameter int CRASH_FRAMES     = 120,
    parameter int DEBOUNCE_FRAMES  = 3
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       frame_tick_i,
    input  logic       btn_start_i,
    input  logic       btn_pause_i,
    input  logic       crash_i,
    input  logic       fuel_empty_i,
    output logic       score_en_o,
    output logic       score_clr_o,
    output logic       world_run_o,
    output logic       crash_flash_o,
    output logic [1:0] countdown_o,
    output logic       game_over_o,
    output logic [2:0] state_o
);

    localparam int DBW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam int CDW = $clog2(COUNTDOWN_FRAMES) + 1;
    localparam int CRW = $clog2(CRASH_FRAMES) + 1;
    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        RUN       = 3'd2,
        PAUSE     = 3'd3,
        CRASH     = 3'd4,
        OVER      = 3'd5
    } state_e;

    logic [1:0]     btnSync1_q;
    logic [1:0]     btnSync2_q;
    logic [DBW-1:0] stableCnt_q [2];
    logic [1:0]     debLvl;
    logic [1:0]     debLvlPrev_q;
    logic [1:0]     pressEvt_q;

    state_e         state_q, state_d;
    logic [CDW-1:0] cdCnt_q, cdCnt_d;
    logic [CRW-1:0] crCnt_q, crCnt_d;
    logic [1:0]     digit_q, digit_d;
    logic           scoreClr_d;

    logic           scoreEn_q;
    logic           scoreClr_q;
    logic           worldRun_q;
    logic           crashFlash_q;
    logic [1:0]     countdown_q;
    logic           gameOver_q;

    logic           startEvt;
    logic           pauseEvt;

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            debLvl[b] = (stableCnt_q[b] == DBW'(DEBOUNCE_FRAMES));
        end
    end

    // Stable counters count frames of a steady high level and saturate at the
    // debounce threshold, so a held button produces one press event only.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            btnSync1_q   <= '0;
            btnSync2_q   <= '0;
            debLvlPrev_q <= '0;
            pressEvt_q   <= '0;
            for (int b = 0; b < 2; b++) begin
                stableCnt_q[b] <= '0;
            end
        end else begin
            btnSync1_q   <= {btn_pause_i, btn_start_i};
            btnSync2_q   <= btnSync1_q;
            debLvlPrev_q <= debLvl;
            pressEvt_q   <= debLvl & ~debLvlPrev_q;
            for (int b = 0; b < 2; b++) begin
                if (!btnSync2_q[b]) begin
                    stableCnt_q[b] <= '0;
                end else if (frame_tick_i && !debLvl[b]) begin
                    stableCnt_q[b] <= stableCnt_q[b] + DBW'(1);
                end
            end
        end
    end

    assign startEvt = pressEvt_q[BTN_START];
    assign pauseEvt = pressEvt_q[BTN_PAUSE];

    always_comb begin
        state_d    = state_q;
        cdCnt_d    = cdCnt_q;
        crCnt_d    = crCnt_q;
        digit_d    = digit_q;
        scoreClr_d = 1'b0;

        case (state_q)
            IDLE, OVER: begin
                if (startEvt) begin
                    state_d    = COUNTDOWN;
                    cdCnt_d    = '0;
                    digit_d    = 2'd3;
                    scoreClr_d = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (frame_tick_i) begin
                    if (cdCnt_q == CDW'(COUNTDOWN_FRAMES - 1)) begin
                        cdCnt_d = '0;
                        if (digit_q == 2'd1) begin
                            state_d = RUN;
                            digit_d = 2'd0;
                        end else begin
                            digit_d = digit_q - 2'd1;
                        end
                    end else begin
                        cdCnt_d = cdCnt_q + CDW'(1);
                    end
                end
            end
            RUN: begin
                if (fuel_empty_i) begin
                    state_d = OVER;
                end else if (crash_i) begin
                    state_d = CRASH;
                    crCnt_d = '0;
                end else if (pauseEvt) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pauseEvt || startEvt) begin
                    state_d = RUN;
                end
            end
            CRASH: begin
                if (frame_tick_i) begin
                    if (crCnt_q == CRW'(CRASH_FRAMES - 1)) begin
                        crCnt_d = '0;
                        state_d = fuel_empty_i ? OVER : RUN;
                    end else begin
                        crCnt_d = crCnt_q + CRW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge as state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            cdCnt_q      <= '0;
            crCnt_q      <= '0;
            digit_q      <= '0;
            scoreEn_q    <= 1'b0;
            scoreClr_q   <= 1'b0;
            worldRun_q   <= 1'b0;
            crashFlash_q <= 1'b0;
            countdown_q  <= '0;
            gameOver_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cdCnt_q      <= cdCnt_d;
            crCnt_q      <= crCnt_d;
            digit_q      <= digit_d;
            scoreEn_q    <= (state_d == RUN);
            scoreClr_q   <= scoreClr_d;
            worldRun_q   <= (state_d == RUN);
            crashFlash_q <= (state_d == CRASH) && (((int'(crCnt_d) / 8) % 2) == 1);
            countdown_q  <= (state_d == COUNTDOWN) ? digit_d : 2'd0;
            gameOver_q   <= (state_d == OVER);
        end
    end

    assign score_en_o    = scoreEn_q;
    assign score_clr_o   = scoreClr_q;
    assign world_run_o   = worldRun_q;
    assign crash_flash_o = crashFlash_q;
    assign countdown_o   = countdown_q;
    assign game_over_o   = gameOver_q;
    assign state_o       = state_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level game sequencer that sits directly upstream of the scoreboard display stage.
- Debounces the start and pause buttons and runs the play-state machine (idle, countdown, run, pause, crash, game over).
- Generates the scoreboard's count enable, the score clear, and the world-scroll enable consumed by the road/car renderers.
- All timing is counted in frames, using the VGA frame_tick strobe.

Parameters:
- COUNTDOWN_FRAMES, 60: frames per countdown step (3 steps: 3,2,1).
- CRASH_FRAMES, 120: frames the game stays frozen after a crash.
- DEBOUNCE_FRAMES, 3: consecutive frame_ticks a button must read stable high to count as pressed.

Ports:
- clk  in  1  system clock (pixel-domain clock shared with scoreboard).
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-clk pulse per frame (start of vertical blank).
- btn_start  in  1  raw start button, asynchronous, active-high.
- btn_pause  in  1  raw pause button, asynchronous, active-high.
- crash  in  1  one-clk collision pulse from the car collision logic.
- fuel_empty  in  1  level; high when fuel reaches zero.
- score_en  out  1  count enable for the scoreboard (its en input).
- score_clr  out  1  one-clk pulse clearing score and fuel at new-game start.
- world_run  out  1  high when road scroll and enemy motion may advance.
- crash_flash  out  1  toggles every 8 frames while in CRASH; 0 otherwise.
- countdown  out  2  digit to display during COUNTDOWN (3,2,1); 0 otherwise.
- game_over  out  1  high in OVER state.
- state  out  3  current state encoding (debug/overlay select).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; all counters 0.
  - All outputs 0, except state=3'd0.
- Button path, per button:
  - Two-flop synchronizer into clk.
  - Stable counter increments on frame_tick while the synced level is 1; clears immediately when the level is 0.
  - Debounced level goes 1 when the counter reaches DEBOUNCE_FRAMES; counter saturates there.
  - Press event = one-clk pulse on the 0->1 edge of the debounced level.
  - Holding a button yields exactly one event; release-and-repress requires a fresh DEBOUNCE_FRAMES.
- State encoding: IDLE=0, COUNTDOWN=1, RUN=2, PAUSE=3, CRASH=4, OVER=5.
- Transitions, evaluated every clk; at most one per clk:
  - IDLE:
    - start event -> COUNTDOWN.
    - score_clr pulses in the same cycle the state register takes COUNTDOWN.
  - COUNTDOWN:
    - Frame counter counts frame_ticks; countdown starts at 3 and decrements every COUNTDOWN_FRAMES.
    - After the third step expires -> RUN.
    - Pause, crash and fuel inputs are ignored.
  - RUN:
    - Priority 1: fuel_empty=1 -> OVER.
    - Priority 2: crash -> CRASH, frame counter cleared.
    - Priority 3: pause event -> PAUSE.
  - PAUSE:
    - pause or start event -> RUN.
    - crash ignored; fuel_empty ignored (fuel is frozen).
  - CRASH:
    - After CRASH_FRAMES frame_ticks: -> OVER if fuel_empty=1, else -> RUN.
    - Button events are discarded.
  - OVER:
    - start event -> COUNTDOWN, with score_clr pulse.
- Outputs are registered and decoded from the next state, so they change in the same edge as state:
  - score_en = (state==RUN).
  - world_run = (state==RUN).
  - game_over = (state==OVER).
- Latency:
  - Raw button edge -> press event: 2 clk (synchronizer) + DEBOUNCE_FRAMES frame_ticks + 1 clk.
  - Press event -> state/outputs: 1 clk.
- Simultaneous events:
  - crash and pause event in the same RUN cycle -> CRASH; the pause event is lost.
  - frame_tick in the same cycle as a state entry is not counted by the new state; counters start from 0 on entry.
- Counter widths: COUNTDOWN/CRASH frame counters sized by $clog2 of their parameter +1. No wrap is possible, because each counter clears on state entry and stops at terminal count.
- Reset mid-operation returns to IDLE asynchronously. score_clr is not asserted by reset; the scoreboard has its own reset.

Test Plan:
- Release reset, hold btn_start high 5 frames (DEBOUNCE_FRAMES=3):
  - Exactly one start event; state 0->1; score_clr high for 1 clk.
  - countdown reads 3 for 60 frames, then 2, then 1; state=2 after frame 180.
  - score_en=1 from then on.
- In RUN, pulse crash:
  - state=4; score_en=0; world_run=0; crash_flash toggles at frames 8,16,…
  - After 120 frames with fuel_empty=0, state returns to 2 and score_en=1.
- In RUN, assert crash and fuel_empty in the same cycle -> state=5, game_over=1, score_en=0.
- In RUN, press pause (held 3 frames) -> state=3, score_en=0. Pulse crash while paused -> still 3. Press pause again -> state=2.
- Bounce btn_pause 1,0,1,0 every frame for 6 frames -> no pause event; state stays 2.
- Assert reset low mid-CRASH at frame 50 -> immediately state=0, all outputs 0. On release, no spurious score_clr.
